execute_memory_stage: RTL and testbench
=======================================

Name: execute_memory_stage

Overview:
- EX/MEM pipeline stage of the 5-stage MIPS core; directly downstream of the decode/execute register.
- Latches the EX-stage results and control, then drives the data-cache request for loads and stores.
- Raises mem_stall to the hazard unit until the cache answers, and provides the MEM-stage values to the MEM/WB register and to the forwarding unit.

Parameters:
TIMEOUT_CYCLES, 255, ACCESS cycles without dhit before mem_err (only with MEM_TIMEOUT_EN)

Ports:
CLK  in  1  core clock, rising edge
nRST  in  1  asynchronous active-low reset
enable  in  1  advance stage (from hazard unit)
flush  in  1  bubble the stage
memtoReg_EX  in  1  instruction is a load
memWr_EX  in  1  instruction is a store
RegWr_EX  in  1  register write enable
Wsel_EX  in  2  writeback select
wdest_EX  in  5  resolved destination register
halt_EX  in  1  halt instruction
alu_out_EX  in  32  ALU result / effective address
busB_EX  in  32  store data
imemaddr_EX  in  32  instruction PC
instr_EX  in  32  instruction word
dhit  in  1  cache access complete
dmemload  in  32  cache read data
memtoReg_MEM, memWr_MEM, RegWr_MEM, halt_MEM  out  1 each  latched control
Wsel_MEM  out  2  latched
wdest_MEM  out  5  latched
alu_out_MEM, busB_MEM, imemaddr_MEM, instr_MEM  out  32 each  latched
dmemload_MEM  out  32  captured load data
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  32  equals alu_out_MEM
dmemstore  out  32  equals busB_MEM
mem_stall  out  1  hold upstream stages
mem_err  out  1  access timeout (feature only)

Behaviour:
- Reset (async, nRST=0): every latched output, dmemload_MEM, state, and counter go to 0. State is IDLE. Requests, mem_stall, and mem_err are 0.
- Edge priority for the pipeline register: nRST, then halt_MEM=1 (hold forever), then mem_stall=1 (hold), then flush (all latched fields become 0), then enable (capture _EX inputs), else hold.
- Flush or enable arriving while mem_stall=1 is ignored. An in-flight access is never aborted.
- The state machine has two states, IDLE and ACCESS.
  - IDLE to ACCESS: on any edge where the register captures with (memtoReg_EX or memWr_EX) = 1.
  - ACCESS with dhit=1: dmemload_MEM is loaded with dmemload (loads only; stores leave it unchanged).
    - Stay in ACCESS if the same edge captures another memory op (back-to-back, zero bubble).
    - Otherwise go to IDLE.
  - ACCESS with dhit=0: stay in ACCESS, register holds.
- Combinational outputs:
  - dmemREN = (state==ACCESS) and memtoReg_MEM.
  - dmemWEN = (state==ACCESS) and memWr_MEM.
  - mem_stall = (state==ACCESS) and not dhit.
- Latency:
  - Non-memory instruction: 1 cycle through the stage.
  - Memory instruction: 1 + N cycles, where N = cycles until dhit (N ≥ 0; dhit in the first ACCESS cycle gives no stall).
- If memtoReg_EX and memWr_EX are both 1, the op is treated as a store only: dmemREN is suppressed.
- halt_MEM is sticky once captured. No further captures or requests occur after it is set; only nRST clears it.
- Reset during ACCESS: the state machine drops to IDLE immediately and request lines deassert asynchronously.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - An 8-bit+ counter clears on entry to ACCESS and increments each ACCESS cycle with dhit=0.
  - On reaching TIMEOUT_CYCLES, mem_err is set (sticky), halt_MEM is forced to 1, and state goes to IDLE.
- Disabled: no counter, mem_err is tied to 0, and the stage waits indefinitely for dhit.

Test Plan:
1. ALU op: enable=1, alu_out_EX=0x0000_1234, RegWr_EX=1, wdest_EX=5. Required next cycle: alu_out_MEM=0x1234, wdest_MEM=5, dmemREN=dmemWEN=0, mem_stall=0.
2. Load, alu_out_EX=0x40, dhit low 3 cycles then high with dmemload=0xDEAD_BEEF. Required: dmemREN=1 for 4 cycles, dmemaddr=0x40, mem_stall=1 for 3 cycles, then dmemload_MEM=0xDEADBEEF and state IDLE.
3. Store then load back-to-back, dhit=1 every cycle. Required: dmemWEN for 1 cycle with dmemstore=busB, then dmemREN for 1 cycle, mem_stall never asserted.
4. flush=1 and enable=1 during a stalled load. Required: register holds. Once dhit=1 and stall is clear, flush=1 zeroes all latched fields.
5. halt_EX=1 captured, then enable=1 with new data. Required: halt_MEM stays 1, other fields frozen. nRST=0 mid-cycle clears all asynchronously.
6. MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, load with dhit=0. Required: mem_err=1 and halt_MEM=1 after 4 ACCESS cycles, then dmemREN=0.

Source files
------------

// File: rtl/execute_memory_stage_if.sv
// Data-cache request/response bus between the EX/MEM stage (master) and the data cache (slave).
interface execute_memory_stage_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/execute_memory_stage.sv
// EX/MEM pipeline register of the 5-stage MIPS core plus the IDLE/ACCESS data-cache request FSM.
// Optional MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES cycles without dhit, raising mem_err.
module execute_memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   memtoReg_EX,
  input  logic                   memWr_EX,
  input  logic                   RegWr_EX,
  input  logic [1:0]             Wsel_EX,
  input  logic [4:0]             wdest_EX,
  input  logic                   halt_EX,
  input  logic [31:0]            alu_out_EX,
  input  logic [31:0]            busB_EX,
  input  logic [31:0]            imemaddr_EX,
  input  logic [31:0]            instr_EX,
  execute_memory_stage_if.master dbus,
  output logic                   memtoReg_MEM,
  output logic                   memWr_MEM,
  output logic                   RegWr_MEM,
  output logic                   halt_MEM,
  output logic [1:0]             Wsel_MEM,
  output logic [4:0]             wdest_MEM,
  output logic [31:0]            alu_out_MEM,
  output logic [31:0]            busB_MEM,
  output logic [31:0]            imemaddr_MEM,
  output logic [31:0]            instr_MEM,
  output logic [31:0]            dmemload_MEM,
  output logic                   mem_stall,
  output logic                   mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic        memtoReg;
    logic        memWr;
    logic        RegWr;
    logic        halt;
    logic [1:0]  Wsel;
    logic [4:0]  wdest;
    logic [31:0] alu_out;
    logic [31:0] busB;
    logic [31:0] imemaddr;
    logic [31:0] instr;
  } stage_t;

  state_t      state;
  state_t      next_state;
  stage_t      mem_q;
  stage_t      ex_d;
  logic [31:0] dload_q;
  logic        capture;
  logic        capture_mem;
  logic        load_done;
  logic        timeout;

  assign ex_d = '{memtoReg: memtoReg_EX, memWr: memWr_EX, RegWr: RegWr_EX, halt: halt_EX,
                  Wsel: Wsel_EX, wdest: wdest_EX, alu_out: alu_out_EX, busB: busB_EX,
                  imemaddr: imemaddr_EX, instr: instr_EX};

  // Stall term rebuilt from state/dhit here so capture does not feed back through mem_stall.
  assign capture     = enable && !flush && !mem_q.halt && !((state == ACCESS) && !dbus.dhit);
  assign capture_mem = capture && (memtoReg_EX || memWr_EX);
  assign load_done   = (state == ACCESS) && dbus.dhit && mem_q.memtoReg && !mem_q.memWr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_q <= '0;
    end else if (timeout) begin
      mem_q.halt <= 1'b1;
    end else if (!mem_q.halt && !mem_stall) begin
      if (flush) begin
        mem_q <= '0;
      end else if (enable) begin
        mem_q <= ex_d;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dload_q <= '0;
    end else if (load_done) begin
      dload_q <= dbus.dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    mem_stall    = 1'b0;
    dbus.dmemREN = 1'b0;
    dbus.dmemWEN = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture_mem) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_stall    = !dbus.dhit;
        // A load+store encoding is serviced as a store only.
        dbus.dmemREN = mem_q.memtoReg && !mem_q.memWr;
        dbus.dmemWEN = mem_q.memWr;
        if (timeout) begin
          next_state = IDLE;
        end else if (dbus.dhit) begin
          next_state = capture_mem ? ACCESS : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout = (state == ACCESS) && !dbus.dhit && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (capture_mem) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !dbus.dhit) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign memtoReg_MEM   = mem_q.memtoReg;
  assign memWr_MEM      = mem_q.memWr;
  assign RegWr_MEM      = mem_q.RegWr;
  assign halt_MEM       = mem_q.halt;
  assign Wsel_MEM       = mem_q.Wsel;
  assign wdest_MEM      = mem_q.wdest;
  assign alu_out_MEM    = mem_q.alu_out;
  assign busB_MEM       = mem_q.busB;
  assign imemaddr_MEM   = mem_q.imemaddr;
  assign instr_MEM      = mem_q.instr;
  assign dmemload_MEM   = dload_q;
  assign dbus.dmemaddr  = mem_q.alu_out;
  assign dbus.dmemstore = mem_q.busB;

endmodule

// File: tb/tb_execute_memory_stage.sv
// Directed bench for execute_memory_stage: cycle-by-cycle vector table plus halt/reset/timeout sequences.
module tb_execute_memory_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        enable, flush, memtoReg_EX, memWr_EX, RegWr_EX, halt_EX;
  logic [1:0]  Wsel_EX;
  logic [4:0]  wdest_EX;
  logic [31:0] alu_out_EX, busB_EX, imemaddr_EX, instr_EX;
  logic        memtoReg_MEM, memWr_MEM, RegWr_MEM, halt_MEM;
  logic [1:0]  Wsel_MEM;
  logic [4:0]  wdest_MEM;
  logic [31:0] alu_out_MEM, busB_MEM, imemaddr_MEM, instr_MEM, dmemload_MEM;
  logic        mem_stall, mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  execute_memory_stage_if dbus();

  execute_memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .nRST(nRST), .enable(enable), .flush(flush),
    .memtoReg_EX(memtoReg_EX), .memWr_EX(memWr_EX), .RegWr_EX(RegWr_EX),
    .Wsel_EX(Wsel_EX), .wdest_EX(wdest_EX), .halt_EX(halt_EX),
    .alu_out_EX(alu_out_EX), .busB_EX(busB_EX), .imemaddr_EX(imemaddr_EX),
    .instr_EX(instr_EX), .dbus(dbus),
    .memtoReg_MEM(memtoReg_MEM), .memWr_MEM(memWr_MEM), .RegWr_MEM(RegWr_MEM),
    .halt_MEM(halt_MEM), .Wsel_MEM(Wsel_MEM), .wdest_MEM(wdest_MEM),
    .alu_out_MEM(alu_out_MEM), .busB_MEM(busB_MEM), .imemaddr_MEM(imemaddr_MEM),
    .instr_MEM(instr_MEM), .dmemload_MEM(dmemload_MEM),
    .mem_stall(mem_stall), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // One record per cycle: inputs driven after the falling edge, expectations observed 1ns later.
  typedef struct {
    logic        en, fl, ld, st, rw;
    logic [4:0]  wd;
    logic [31:0] alu, busb;
    logic        hit;
    logic [31:0] dl;
    logic [31:0] e_alu;
    logic [4:0]  e_wd;
    logic        e_rw, e_ren, e_wen, e_stall;
    logic [31:0] e_busb, e_dl;
  } vec_t;

  vec_t vt [19];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b0; flush = 1'b0; memtoReg_EX = 1'b0; memWr_EX = 1'b0; RegWr_EX = 1'b0;
    halt_EX = 1'b0; Wsel_EX = 2'b00; wdest_EX = 5'd0; alu_out_EX = '0; busB_EX = '0;
    imemaddr_EX = '0; instr_EX = '0; dbus.dhit = 1'b0; dbus.dmemload = '0;
  endtask

  task automatic drive(input vec_t v);
    idle_inputs();
    enable = v.en; flush = v.fl; memtoReg_EX = v.ld; memWr_EX = v.st; RegWr_EX = v.rw;
    wdest_EX = v.wd; alu_out_EX = v.alu; busB_EX = v.busb;
    dbus.dhit = v.hit; dbus.dmemload = v.dl;
  endtask

  initial begin
    //        en    fl    ld    st    rw    wd     alu           busb          hit   dl
    //        e_alu         e_wd   e_rw  e_ren e_wen e_stl e_busb        e_dl
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 32'h0000_0011, 1'b0, 32'h0,
               32'h0,         5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 32'h0,
               32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0011, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_0040, 32'h0,         1'b0, 32'h0,
               32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0011, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  32'h0000_0099, 32'h0,         1'b0, 32'h0,
               32'h0000_0040, 5'd8,  1'b1, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0};
    vt[4]  = vt[3];
    vt[5]  = vt[3];
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF,
               32'h0000_0040, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 32'h0,
               32'h0000_0040, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0080, 32'hCAFE_0001, 1'b1, 32'h0,
               32'h0000_0040, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0084, 32'h0,         1'b1, 32'h1111_2222,
               32'h0000_0080, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 32'hDEAD_BEEF};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b1, 32'h1111_2222,
               32'h0000_0084, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 32'h0,
               32'h0000_0084, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1111_2222};
    vt[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_0200, 32'h0000_0005, 1'b0, 32'h0,
               32'h0000_0084, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1111_2222};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0000_0300, 32'h0,         1'b0, 32'h0,
               32'h0000_0200, 5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0005, 32'h1111_2222};
    vt[14] = vt[13];
    vt[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b1, 32'h0BAD_F00D,
               32'h0000_0200, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h1111_2222};
    vt[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0500, 32'h0000_0077, 1'b0, 32'h0,
               32'h0,         5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0BAD_F00D};
    vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b1, 32'hFFFF_0000,
               32'h0000_0500, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 32'h0BAD_F00D};
    vt[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 32'h0,
               32'h0000_0500, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0BAD_F00D};

    idle_inputs();
    nRST = 1'b0;
    #2;
    chk32("rst alu_out_MEM", alu_out_MEM, 32'h0);
    chk32("rst dmemload_MEM", dmemload_MEM, 32'h0);
    chk1("rst halt_MEM", halt_MEM, 1'b0);
    chk1("rst dmemREN", dbus.dmemREN, 1'b0);
    chk1("rst mem_stall", mem_stall, 1'b0);
    chk1("rst mem_err", mem_err, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int unsigned i = 0; i < 19; i++) begin
      @(negedge CLK);
      drive(vt[i]);
      #1;
      chk32($sformatf("v%0d alu_out_MEM", i), alu_out_MEM, vt[i].e_alu);
      chk32($sformatf("v%0d wdest_MEM", i), {27'b0, wdest_MEM}, {27'b0, vt[i].e_wd});
      chk1($sformatf("v%0d RegWr_MEM", i), RegWr_MEM, vt[i].e_rw);
      chk1($sformatf("v%0d dmemREN", i), dbus.dmemREN, vt[i].e_ren);
      chk1($sformatf("v%0d dmemWEN", i), dbus.dmemWEN, vt[i].e_wen);
      chk1($sformatf("v%0d mem_stall", i), mem_stall, vt[i].e_stall);
      chk32($sformatf("v%0d dmemaddr", i), dbus.dmemaddr, vt[i].e_alu);
      chk32($sformatf("v%0d dmemstore", i), dbus.dmemstore, vt[i].e_busb);
      chk32($sformatf("v%0d dmemload_MEM", i), dmemload_MEM, vt[i].e_dl);
      chk1($sformatf("v%0d mem_err", i), mem_err, 1'b0);
    end

    // Halt capture, then attempted capture and flush are both ignored.
    @(negedge CLK);
    idle_inputs();
    enable = 1'b1; halt_EX = 1'b1; RegWr_EX = 1'b1; wdest_EX = 5'd2; Wsel_EX = 2'b11;
    alu_out_EX = 32'h0000_0600; busB_EX = 32'h0000_0066;
    imemaddr_EX = 32'h0040_0010; instr_EX = 32'h0000_000C;
    @(negedge CLK);
    idle_inputs();
    enable = 1'b1; memWr_EX = 1'b1; wdest_EX = 5'd4; Wsel_EX = 2'b01;
    alu_out_EX = 32'h0000_0700; busB_EX = 32'h0000_0077;
    imemaddr_EX = 32'h0040_0014; instr_EX = 32'h0000_00AA;
    #1;
    chk1("halt captured", halt_MEM, 1'b1);
    chk32("halt alu_out_MEM", alu_out_MEM, 32'h0000_0600);
    chk32("halt busB_MEM", busB_MEM, 32'h0000_0066);
    chk32("halt imemaddr_MEM", imemaddr_MEM, 32'h0040_0010);
    chk32("halt instr_MEM", instr_MEM, 32'h0000_000C);
    chk32("halt Wsel_MEM", {30'b0, Wsel_MEM}, 32'd3);
    chk32("halt wdest_MEM", {27'b0, wdest_MEM}, 32'd2);
    @(negedge CLK);
    flush = 1'b1;
    #1;
    chk1("halt sticky", halt_MEM, 1'b1);
    chk32("halt frozen alu", alu_out_MEM, 32'h0000_0600);
    chk1("halt memWr frozen", memWr_MEM, 1'b0);
    chk1("halt no WEN", dbus.dmemWEN, 1'b0);
    @(negedge CLK);
    #1;
    chk32("halt flush ignored", alu_out_MEM, 32'h0000_0600);
    #3;
    nRST = 1'b0;
    #1;
    chk1("async rst halt", halt_MEM, 1'b0);
    chk32("async rst alu", alu_out_MEM, 32'h0);
    chk32("async rst pc", imemaddr_MEM, 32'h0);
    chk32("async rst dload", dmemload_MEM, 32'h0);
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b1;

    // Reset while an access is in flight drops the request without a clock edge.
    @(negedge CLK);
    enable = 1'b1; memtoReg_EX = 1'b1; alu_out_EX = 32'h0000_0044;
    @(negedge CLK);
    idle_inputs();
    #1;
    chk1("inflight REN", dbus.dmemREN, 1'b1);
    chk1("inflight stall", mem_stall, 1'b1);
    #3;
    nRST = 1'b0;
    #1;
    chk1("inflight rst REN", dbus.dmemREN, 1'b0);
    chk1("inflight rst stall", mem_stall, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    chk1("post rst REN", dbus.dmemREN, 1'b0);

    // Load that never sees dhit.
    @(negedge CLK);
    enable = 1'b1; memtoReg_EX = 1'b1; alu_out_EX = 32'h0000_0048;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge CLK);
      idle_inputs();
      #1;
      chk1($sformatf("wait%0d REN", c), dbus.dmemREN, 1'b1);
      chk1($sformatf("wait%0d mem_err", c), mem_err, 1'b0);
    end
    @(negedge CLK);
    #1;
`ifdef MEM_TIMEOUT_EN
    chk1("timeout mem_err", mem_err, 1'b1);
    chk1("timeout halt_MEM", halt_MEM, 1'b1);
    chk1("timeout REN", dbus.dmemREN, 1'b0);
    chk1("timeout stall", mem_stall, 1'b0);
    chk32("timeout addr held", dbus.dmemaddr, 32'h0000_0048);
`else
    chk1("no timeout REN", dbus.dmemREN, 1'b1);
    chk1("no timeout stall", mem_stall, 1'b1);
    chk1("no timeout mem_err", mem_err, 1'b0);
    chk1("no timeout halt", halt_MEM, 1'b0);
    dbus.dhit = 1'b1;
    dbus.dmemload = 32'h1234_5678;
    @(negedge CLK);
    dbus.dhit = 1'b0;
    #1;
    chk32("late hit dload", dmemload_MEM, 32'h1234_5678);
    chk1("late hit REN", dbus.dmemREN, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
